switch_alloc: RTL and testbench

Per-router switch allocator for the 5-port mesh router (ports E, W, N, S, local inject/eject). Each cycle it collects one output-port request per input port and runs a round-robin arbiter with wormhole locking per output. It drives the per-input grants and forwards the request codes that the select generator consumes to build crossbar selects. It sits between the input buffers (request side) and the select generator / crossbar (grant side).

---
 rtl/noc_pkg.sv | 24 ++
 rtl/rr_arb_out.sv | 59 +++++
 rtl/switch_alloc.sv | 103 ++++++++++
 tb/tb_switch_alloc.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: port codes, port count and the per-input request bundle.
// Used by the switch allocator, the select generator and the crossbar.
package noc_pkg;

    localparam int NPORTS = 5;

    localparam logic [2:0] PORT_E  = 3'd0;
    localparam logic [2:0] PORT_W  = 3'd1;
    localparam logic [2:0] PORT_N  = 3'd2;
    localparam logic [2:0] PORT_S  = 3'd3;
    localparam logic [2:0] PORT_EJ = 3'd4;

    typedef struct packed {
        logic       v;
        logic [2:0] req;
        logic       tail;
    } req_t;

    // Increment a port index modulo NPORTS (valid only for 0..4).
    function automatic logic [2:0] wrap_inc(input logic [2:0] p);
        return (p == PORT_EJ) ? PORT_E : p + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arb_out.sv
// Round-robin arbiter for a single output port with optional wormhole locking.
// Grants are combinational from the registered pointer/lock/owner and the candidate vector.
module rr_arb_out
    import noc_pkg::*;
#(
    parameter logic LOCK_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NPORTS-1:0] cand,
    input  logic [NPORTS-1:0] tail,
    output logic [NPORTS-1:0] gnt
);

    logic [2:0] ptr;
    logic [2:0] own;
    logic       lk;
    logic [2:0] win;
    logic [2:0] idx;
    logic       hit;

    // A locked output serves only its owner, even when the owner is idle.
    always_comb begin
        win = ptr;
        idx = ptr;
        hit = 1'b0;
        if (lk) begin
            win = own;
            hit = cand[own];
        end else begin
            for (int k = 0; k < NPORTS; k++) begin
                if (!hit && cand[idx]) begin
                    hit = 1'b1;
                    win = idx;
                end
                idx = wrap_inc(idx);
            end
        end
    end

    assign gnt = (hit && reset) ? (NPORTS'(1) << win) : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= PORT_E;
            own <= PORT_E;
            lk  <= 1'b0;
        end else if (hit) begin
            ptr <= wrap_inc(win);
            if (tail[win]) begin
                lk <= 1'b0;
            end else if (LOCK_EN) begin
                lk  <= 1'b1;
                own <= win;
            end
        end
    end

endmodule

// File: rtl/switch_alloc.sv
// Five-port switch allocator: one round-robin/wormhole arbiter per output, grants ORed per input.
// Handshake: an input holds *_v/*_req/*_tail stable until its *_g is 1; a grant is the transfer at that edge.
module switch_alloc
    import noc_pkg::*;
#(
    parameter logic LOCK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       e_v,
    input  logic       w_v,
    input  logic       n_v,
    input  logic       s_v,
    input  logic       inject_v,
    input  logic [2:0] e_req,
    input  logic [2:0] w_req,
    input  logic [2:0] n_req,
    input  logic [2:0] s_req,
    input  logic [2:0] inject_req,
    input  logic       e_tail,
    input  logic       w_tail,
    input  logic       n_tail,
    input  logic       s_tail,
    input  logic       inject_tail,
    input  logic [4:0] out_rdy,
    output logic       e_g,
    output logic       w_g,
    output logic       n_g,
    output logic       s_g,
    output logic       inject_g,
    output logic [2:0] e_req_o,
    output logic [2:0] w_req_o,
    output logic [2:0] n_req_o,
    output logic [2:0] s_req_o,
    output logic [2:0] inject_req_o,
    output logic       bad_req
);

    req_t              req_in [NPORTS];
    logic [NPORTS-1:0] cand   [NPORTS];
    logic [NPORTS-1:0] gnt_o  [NPORTS];
    logic [NPORTS-1:0] tails;
    logic [NPORTS-1:0] gnt_in;
    logic [NPORTS-1:0] bad_now;

    assign req_in[0] = {e_v,      e_req,      e_tail};
    assign req_in[1] = {w_v,      w_req,      w_tail};
    assign req_in[2] = {n_v,      n_req,      n_tail};
    assign req_in[3] = {s_v,      s_req,      s_tail};
    assign req_in[4] = {inject_v, inject_req, inject_tail};

    // Invalid codes never match any output, so they are never candidates.
    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            cand[o] = '0;
            for (int i = 0; i < NPORTS; i++) begin
                cand[o][i] = req_in[i].v && (req_in[i].req == 3'(o)) && out_rdy[o];
            end
        end
        for (int i = 0; i < NPORTS; i++) begin
            tails[i]   = req_in[i].tail;
            bad_now[i] = req_in[i].v && (req_in[i].req > PORT_EJ);
        end
    end

    for (genvar o = 0; o < NPORTS; o++) begin : g_arb
        rr_arb_out #(.LOCK_EN(LOCK_EN)) u_arb (
            .clk  (clk),
            .reset(reset),
            .cand (cand[o]),
            .tail (tails),
            .gnt  (gnt_o[o])
        );
    end

    always_comb begin
        gnt_in = '0;
        for (int o = 0; o < NPORTS; o++) begin
            gnt_in = gnt_in | gnt_o[o];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bad_req <= 1'b0;
        end else begin
            bad_req <= |bad_now;
        end
    end

    assign e_g      = gnt_in[0];
    assign w_g      = gnt_in[1];
    assign n_g      = gnt_in[2];
    assign s_g      = gnt_in[3];
    assign inject_g = gnt_in[4];

    assign e_req_o      = e_req;
    assign w_req_o      = w_req;
    assign n_req_o      = n_req;
    assign s_req_o      = s_req;
    assign inject_req_o = inject_req;

endmodule

// File: tb/tb_switch_alloc.sv
// Bench for switch_alloc: directed scenarios plus randomized packet traffic, all checked
// against a behavioural model of per-output round-robin and wormhole ownership.
module tb_switch_alloc;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] v;
    logic [4:0] tl;
    logic [2:0] rq [5];
    logic [4:0] out_rdy;
    logic       e_g, w_g, n_g, s_g, inject_g;
    logic [2:0] e_req_o, w_req_o, n_req_o, s_req_o, inject_req_o;
    logic       bad_req;
    logic [4:0] g;
    logic [14:0] ro;

    always #5 clk = ~clk;

    switch_alloc dut (
        .clk(clk), .reset(reset),
        .e_v(v[0]), .w_v(v[1]), .n_v(v[2]), .s_v(v[3]), .inject_v(v[4]),
        .e_req(rq[0]), .w_req(rq[1]), .n_req(rq[2]), .s_req(rq[3]), .inject_req(rq[4]),
        .e_tail(tl[0]), .w_tail(tl[1]), .n_tail(tl[2]), .s_tail(tl[3]), .inject_tail(tl[4]),
        .out_rdy(out_rdy),
        .e_g(e_g), .w_g(w_g), .n_g(n_g), .s_g(s_g), .inject_g(inject_g),
        .e_req_o(e_req_o), .w_req_o(w_req_o), .n_req_o(n_req_o), .s_req_o(s_req_o),
        .inject_req_o(inject_req_o),
        .bad_req(bad_req)
    );

    assign g  = {inject_g, s_g, n_g, w_g, e_g};
    assign ro = {inject_req_o, s_req_o, n_req_o, w_req_o, e_req_o};

    // Reference model state: per-output pointer, lock flag and owner.
    int         m_ptr [5];
    int         m_lk  [5];
    int         m_own [5];
    logic [4:0] exp_g;
    logic [0:0] exp_q [$];
    int         rem [5];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [4:0] model_grant();
        logic [4:0] r = '0;
        bit found;
        int i;
        if (!reset) return '0;
        for (int o = 0; o < 5; o++) begin
            if (!out_rdy[o]) continue;
            if (m_lk[o] != 0) begin
                if (v[m_own[o]] && rq[m_own[o]] == 3'(o)) r[m_own[o]] = 1'b1;
            end else begin
                found = 0;
                for (int k = 0; k < 5; k++) begin
                    i = (m_ptr[o] + k) % 5;
                    if (!found && v[i] && rq[i] == 3'(o)) begin
                        r[i] = 1'b1;
                        found = 1;
                    end
                end
            end
        end
        return r;
    endfunction

    task automatic model_update();
        logic bad = 1'b0;
        int o;
        if (!reset) begin
            for (int k = 0; k < 5; k++) begin
                m_ptr[k] = 0; m_lk[k] = 0; m_own[k] = 0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (exp_g[i]) begin
                    o = int'(rq[i]);
                    m_ptr[o] = (i + 1) % 5;
                    if (tl[i]) m_lk[o] = 0;
                    else begin m_lk[o] = 1; m_own[o] = i; end
                end
                if (v[i] && rq[i] > 3'd4) bad = 1'b1;
            end
        end
        exp_q.push_back(bad);
    endtask

    // One cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic step(input string tag, input bit use_exp, input logic [4:0] exp);
        @(negedge clk);
        exp_g = model_grant();
        check("grant", {27'd0, g}, {27'd0, exp_g});
        if (use_exp) check(tag, {27'd0, g}, {27'd0, exp});
        check("req_o", {17'd0, ro}, {17'd0, rq[4], rq[3], rq[2], rq[1], rq[0]});
        if (exp_q.size() > 0) check("bad_req", {31'd0, bad_req}, {31'd0, exp_q.pop_front()});
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clr();
        v = '0;
        tl = '0;
        for (int i = 0; i < 5; i++) rq[i] = 3'd0;
    endtask

    task automatic set_in(input int i, input logic [2:0] r, input logic t);
        v[i] = 1'b1;
        rq[i] = r;
        tl[i] = t;
    endtask

    initial begin
        reset = 1'b0;
        out_rdy = 5'b11111;
        clr();
        for (int k = 0; k < 5; k++) begin
            m_ptr[k] = 0; m_lk[k] = 0; m_own[k] = 0; rem[k] = 0;
        end
        exp_g = '0;
        repeat (2) @(posedge clk);
        exp_q.push_back(1'b0);
        #1;

        // Reset holds grants low; first grant after release goes to E.
        for (int i = 0; i < 5; i++) set_in(i, 3'd0, 1'b1);
        step("rst_g", 1, 5'b00000);
        reset = 1'b1;
        step("rst_first", 1, 5'b00001);
        clr();

        // Round-robin rotation on eject.
        for (int i = 0; i < 5; i++) set_in(i, 3'd4, 1'b1);
        for (int k = 0; k < 5; k++) step("rr", 1, 5'b00001 << k);
        step("rr_wrap", 1, 5'b00001);
        clr();

        // Wormhole: W holds N for a 3-flit packet while S waits.
        set_in(1, 3'd2, 1'b0);
        set_in(3, 3'd2, 1'b1);
        step("wh1", 1, 5'b00010);
        step("wh2", 1, 5'b00010);
        tl[1] = 1'b1;
        step("wh3", 1, 5'b00010);
        v[1] = 1'b0;
        step("wh4", 1, 5'b01000);
        clr();

        // Backpressure inside a locked E->W packet.
        set_in(0, 3'd1, 1'b0);
        set_in(2, 3'd1, 1'b1);
        step("bp1", 1, 5'b00001);
        out_rdy[1] = 1'b0;
        step("bp_stall", 1, 5'b00000);
        out_rdy = 5'b11111;
        step("bp_resume", 1, 5'b00001);
        tl[0] = 1'b1;
        step("bp_tail", 1, 5'b00001);
        v[0] = 1'b0;
        step("bp_next", 1, 5'b00100);
        clr();

        // Parallel grants with one invalid requester.
        set_in(0, 3'd2, 1'b1);
        set_in(2, 3'd0, 1'b1);
        set_in(3, 3'd3, 1'b1);
        set_in(4, 3'd4, 1'b1);
        set_in(1, 3'd5, 1'b1);
        step("par", 1, 5'b11101);
        clr();
        check("bad_pulse", {31'd0, bad_req}, 32'd1);

        // Reset in the middle of a packet drops the lock.
        set_in(2, 3'd0, 1'b0);
        step("mp_lock", 1, 5'b00100);
        set_in(3, 3'd0, 1'b1);
        reset = 1'b0;
        step("mp_rst", 1, 5'b00000);
        reset = 1'b1;
        v[2] = 1'b0;
        step("mp_after", 1, 5'b01000);
        clr();

        // Randomized packet traffic with backpressure and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) != 0);
            for (int b = 0; b < 5; b++) out_rdy[b] = ($urandom_range(0, 3) != 0);
            step("", 0, 5'b00000);
            for (int i = 0; i < 5; i++) begin
                if (v[i] && rq[i] > 3'd4) begin
                    v[i] = 1'b0;
                end else if (v[i] && exp_g[i]) begin
                    if (tl[i]) v[i] = 1'b0;
                    else begin
                        rem[i]--;
                        tl[i] = (rem[i] == 1);
                    end
                end
                if (!v[i] && $urandom_range(0, 1) == 1) begin
                    if ($urandom_range(0, 15) == 0) begin
                        rq[i] = 3'($urandom_range(5, 7));
                        tl[i] = 1'b1;
                    end else begin
                        rq[i] = 3'($urandom_range(0, 4));
                        rem[i] = $urandom_range(1, 3);
                        tl[i] = (rem[i] == 1);
                    end
                    v[i] = 1'b1;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
